// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: RAW stall detection, taken-branch squash and post-HALT drain
// for the 5-stage core. Define FORWARDING_EN when the datapath forwards EX/MEM results (load-use only).
module pipe_hazard_ctrl #(
   parameter int REG_ADDR_W   = 5,
   parameter int CNT_W        = 32,
   parameter int DRAIN_CYCLES = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_uses_rs,
   input  logic                  id_uses_rt,
   input  logic                  id_is_halt,
   input  logic                  ex_valid,
   input  logic                  ex_regwrite,
   input  logic                  ex_is_load,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  mem_valid,
   input  logic                  mem_regwrite,
   input  logic [REG_ADDR_W-1:0] mem_rd,
   input  logic                  branch_taken,
   output logic                  hazard_detected,
   output logic                  halt_signal,
   output logic                  if_id_hold,
   output logic                  if_id_flush,
   output logic                  id_ex_bubble,
   output logic                  pipe_done,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic [CNT_W-1:0]      flush_cnt
);

   typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

   localparam int DC_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   state_t          state, state_next;
   logic [DC_W-1:0] drain_cnt;
   logic            ex_match, mem_match, raw_hazard;
   logic            halt_det, stall, flush_evt;

   function automatic logic src_match(
      input logic [REG_ADDR_W-1:0] rd,
      input logic [REG_ADDR_W-1:0] rs,
      input logic [REG_ADDR_W-1:0] rt,
      input logic                  uses_rs,
      input logic                  uses_rt
   );
      return (rd != '0) && ((uses_rs && rs == rd) || (uses_rt && rt == rd));
   endfunction

   assign ex_match  = src_match(ex_rd,  id_rs, id_rt, id_uses_rs, id_uses_rt);
   assign mem_match = src_match(mem_rd, id_rs, id_rt, id_uses_rs, id_uses_rt);

`ifdef FORWARDING_EN
   assign raw_hazard = ex_valid && ex_regwrite && ex_is_load && ex_match;
`else
   // A writer in WB is invisible here: the register file writes in the first half-cycle.
   assign raw_hazard = (ex_valid && ex_regwrite && ex_match) ||
                       (mem_valid && mem_regwrite && mem_match);
`endif

   assign halt_det  = (state == RUN) && id_valid && id_is_halt && !branch_taken;
   assign stall     = (state == RUN) && id_valid && !branch_taken && raw_hazard;
   assign flush_evt = (state == RUN) && branch_taken;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= RUN;
         drain_cnt <= '0;
         pipe_done <= 1'b0;
      end else begin
         state     <= state_next;
         pipe_done <= pipe_done || (state_next == DONE);
         if (halt_det)
            drain_cnt <= DC_W'(DRAIN_CYCLES - 1);
         else if (state == DRAIN && drain_cnt != '0)
            drain_cnt <= drain_cnt - 1'b1;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         RUN:     if (halt_det) state_next = DRAIN;
         DRAIN:   if (drain_cnt == '0) state_next = DONE;
         DONE:    state_next = DONE;
         default: state_next = RUN;
      endcase
   end

   // NOTE: every output gets a default first so no path through the case infers a latch.
   always_comb begin
      hazard_detected = 1'b0;
      halt_signal     = 1'b0;
      if_id_hold      = 1'b0;
      if_id_flush     = 1'b0;
      id_ex_bubble    = 1'b0;
      if (!rst) begin
         unique case (state)
            RUN: begin
               if (branch_taken) begin
                  if_id_flush  = 1'b1;
                  id_ex_bubble = 1'b1;
               end else begin
                  if (stall) begin
                     hazard_detected = 1'b1;
                     if_id_hold      = 1'b1;
                     id_ex_bubble    = 1'b1;
                  end
                  if (halt_det) begin
                     halt_signal = 1'b1;
                     if_id_flush = 1'b1;
                  end
               end
            end
            DRAIN, DONE: begin
               halt_signal = 1'b1;
               if_id_flush = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Counters only move in RUN, so they are frozen through DRAIN and DONE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall)     stall_cnt <= stall_cnt + 1'b1;
         if (flush_evt) flush_cnt <= flush_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: combinational vector table plus multi-cycle
// load-use, branch, HALT-drain and reset-during-drain sequences.
module tb_pipe_hazard_ctrl;

   localparam int RW = 5;
   localparam int CW = 32;
   localparam int DC = 3;
`ifdef FORWARDING_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          id_valid, id_uses_rs, id_uses_rt, id_is_halt;
   logic [RW-1:0] id_rs, id_rt, ex_rd, mem_rd;
   logic          ex_valid, ex_regwrite, ex_is_load;
   logic          mem_valid, mem_regwrite, branch_taken;
   logic          hazard_detected, halt_signal, if_id_hold, if_id_flush, id_ex_bubble, pipe_done;
   logic [CW-1:0] stall_cnt, flush_cnt;

   int n_vec = 0;
   int n_err = 0;
   int exp_stall = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.REG_ADDR_W(RW), .CNT_W(CW), .DRAIN_CYCLES(DC)) dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_is_halt(id_is_halt),
      .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
      .mem_valid(mem_valid), .mem_regwrite(mem_regwrite), .mem_rd(mem_rd),
      .branch_taken(branch_taken),
      .hazard_detected(hazard_detected), .halt_signal(halt_signal),
      .if_id_hold(if_id_hold), .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
      .pipe_done(pipe_done), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   typedef struct {
      int    id_valid, id_rs, id_rt, uses_rs, uses_rt, is_halt;
      int    ex_valid, ex_regwrite, ex_is_load, ex_rd;
      int    mem_valid, mem_regwrite, mem_rd, branch;
      int    e_haz, e_halt, e_hold, e_flush, e_bub;
      string name;
   } vec_t;

   vec_t tbl[13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic bit1(input string name, input logic act, input int exp);
      check(name, {31'b0, act}, 32'(exp));
   endtask

   task automatic idle();
      id_valid = 0; id_rs = '0; id_rt = '0; id_uses_rs = 0; id_uses_rt = 0; id_is_halt = 0;
      ex_valid = 0; ex_regwrite = 0; ex_is_load = 0; ex_rd = '0;
      mem_valid = 0; mem_regwrite = 0; mem_rd = '0; branch_taken = 0;
   endtask

   task automatic drive(input vec_t v);
      id_valid = v.id_valid[0]; id_rs = v.id_rs[RW-1:0]; id_rt = v.id_rt[RW-1:0];
      id_uses_rs = v.uses_rs[0]; id_uses_rt = v.uses_rt[0]; id_is_halt = v.is_halt[0];
      ex_valid = v.ex_valid[0]; ex_regwrite = v.ex_regwrite[0]; ex_is_load = v.ex_is_load[0];
      ex_rd = v.ex_rd[RW-1:0]; mem_valid = v.mem_valid[0]; mem_regwrite = v.mem_regwrite[0];
      mem_rd = v.mem_rd[RW-1:0]; branch_taken = v.branch[0];
   endtask

   task automatic load_use(input int rd);
      id_valid = 1; id_rs = rd[RW-1:0]; id_uses_rs = 1;
      ex_valid = 1; ex_regwrite = 1; ex_is_load = 1; ex_rd = rd[RW-1:0];
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int nf;
      nf = FWD ? 0 : 1;
      //          idv rs rt urs urt hlt exv exw exl exrd mv mw mrd br  haz hlt hold fl bub
      tbl[0]  = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0,  0,  0, 0, 0, 0, 0, "idle"};
      tbl[1]  = '{1, 5, 0, 1, 0, 0,  1, 1, 1, 5,  0, 0, 0,  0,  1, 0, 1, 0, 1, "load_use_rs"};
      tbl[2]  = '{1, 5, 0, 1, 0, 0,  1, 1, 0, 5,  0, 0, 0,  0,  nf, 0, nf, 0, nf, "alu_ex_rs"};
      tbl[3]  = '{1, 0, 0, 1, 1, 0,  1, 1, 1, 0,  1, 1, 0,  0,  0, 0, 0, 0, 0, "reg0"};
      tbl[4]  = '{1, 2, 7, 1, 1, 0,  0, 0, 0, 0,  1, 1, 7,  0,  nf, 0, nf, 0, nf, "mem_writer_rt"};
      tbl[5]  = '{1, 5, 0, 0, 0, 0,  1, 1, 1, 5,  0, 0, 0,  0,  0, 0, 0, 0, 0, "rs_unused"};
      tbl[6]  = '{1, 5, 0, 1, 0, 0,  0, 1, 1, 5,  0, 0, 0,  0,  0, 0, 0, 0, 0, "ex_invalid"};
      tbl[7]  = '{0, 5, 0, 1, 0, 0,  1, 1, 1, 5,  0, 0, 0,  0,  0, 0, 0, 0, 0, "id_invalid"};
      tbl[8]  = '{1, 5, 0, 1, 0, 0,  1, 1, 1, 5,  0, 0, 0,  1,  0, 0, 0, 1, 1, "branch_wins"};
      tbl[9]  = '{1, 0, 0, 0, 0, 1,  0, 0, 0, 0,  0, 0, 0,  0,  0, 1, 0, 1, 0, "halt_id"};
      tbl[10] = '{1, 0, 0, 0, 0, 1,  0, 0, 0, 0,  0, 0, 0,  1,  0, 0, 0, 1, 1, "halt_wrong_path"};
      tbl[11] = '{1, 5, 0, 1, 0, 0,  1, 0, 1, 5,  1, 0, 5,  0,  0, 0, 0, 0, 0, "no_regwrite"};
      tbl[12] = '{1, 1, 3, 1, 1, 0,  1, 1, 1, 3,  0, 0, 0,  0,  1, 0, 1, 0, 1, "load_use_rt"};

      // Reset state, with a HALT and hazard driven to show outputs are forced low.
      idle();
      rst = 1;
      #2;
      load_use(5); id_is_halt = 1; branch_taken = 1;
      #1;
      bit1("rst_halt", halt_signal, 0);
      bit1("rst_haz", hazard_detected, 0);
      bit1("rst_flush", if_id_flush, 0);
      bit1("rst_bub", id_ex_bubble, 0);
      bit1("rst_done", pipe_done, 0);
      check("rst_stall_cnt", stall_cnt, 0);
      check("rst_flush_cnt", flush_cnt, 0);
      idle();
      step();
      rst = 0;

      // Combinational table: inputs withdrawn before the next edge so state never moves.
      foreach (tbl[i]) begin
         step();
         drive(tbl[i]);
         #1;
         bit1($sformatf("%s haz", tbl[i].name), hazard_detected, tbl[i].e_haz);
         bit1($sformatf("%s halt", tbl[i].name), halt_signal, tbl[i].e_halt);
         bit1($sformatf("%s hold", tbl[i].name), if_id_hold, tbl[i].e_hold);
         bit1($sformatf("%s flush", tbl[i].name), if_id_flush, tbl[i].e_flush);
         bit1($sformatf("%s bub", tbl[i].name), id_ex_bubble, tbl[i].e_bub);
         idle();
      end
      step();
      check("table_stall_cnt", stall_cnt, 0);
      check("table_flush_cnt", flush_cnt, 0);

      // Load-use: LW r5 moves EX -> MEM while ADD r5 waits in ID.
      load_use(5);
      #1 bit1("lu_c1_haz", hazard_detected, 1);
      step();
      ex_valid = 0; mem_valid = 1; mem_regwrite = 1; mem_rd = 5;
      #1 bit1("lu_c2_haz", hazard_detected, nf);
      step();
      mem_valid = 0;
      #1 bit1("lu_c3_haz", hazard_detected, 0);
      exp_stall = FWD ? 1 : 2;
      check("lu_stall_cnt", stall_cnt, 32'(exp_stall));

      // Non-load writer r5 followed by consumer.
      idle();
      id_valid = 1; id_rs = 5; id_uses_rs = 1; ex_valid = 1; ex_regwrite = 1; ex_rd = 5;
      #1 bit1("alu_c1_haz", hazard_detected, nf);
      step();
      ex_valid = 0; mem_valid = 1; mem_regwrite = 1; mem_rd = 5;
      #1 bit1("alu_c2_haz", hazard_detected, nf);
      step();
      idle();
      exp_stall += 2 * nf;
      check("alu_stall_cnt", stall_cnt, 32'(exp_stall));

      // Register 0 writers in EX and MEM.
      id_valid = 1; id_uses_rs = 1; id_uses_rt = 1;
      ex_valid = 1; ex_regwrite = 1; ex_is_load = 1; mem_valid = 1; mem_regwrite = 1;
      #1 bit1("r0_haz", hazard_detected, 0);
      step();
      idle();
      check("r0_stall_cnt", stall_cnt, 32'(exp_stall));

      // Branch together with load-use.
      load_use(6); branch_taken = 1;
      #1;
      bit1("brs_flush", if_id_flush, 1);
      bit1("brs_bub", id_ex_bubble, 1);
      bit1("brs_haz", hazard_detected, 0);
      bit1("brs_hold", if_id_hold, 0);
      step();
      idle();
      check("brs_flush_cnt", flush_cnt, 1);
      check("brs_stall_cnt", stall_cnt, 32'(exp_stall));

      // HALT drain: HALT in ID at cycle T, pipe_done at T+DC+1.
      id_valid = 1; id_is_halt = 1;
      #1;
      bit1("halt_T_sig", halt_signal, 1);
      bit1("halt_T_flush", if_id_flush, 1);
      bit1("halt_T_bub", id_ex_bubble, 0);
      for (int c = 1; c <= DC + 2; c++) begin
         step();
         idle();
         load_use(7); branch_taken = 1;
         #1;
         bit1($sformatf("halt_T+%0d_sig", c), halt_signal, 1);
         bit1($sformatf("halt_T+%0d_haz", c), hazard_detected, 0);
         bit1($sformatf("halt_T+%0d_flush", c), if_id_flush, 1);
         bit1($sformatf("halt_T+%0d_done", c), pipe_done, (c >= DC + 1) ? 1 : 0);
      end
      step();
      check("halt_frozen_stall", stall_cnt, 32'(exp_stall));
      check("halt_frozen_flush", flush_cnt, 1);
      bit1("halt_done_held", pipe_done, 1);

      // Reset during drain: recover, stall once, HALT at T, pulse rst at T+2.
      idle();
      rst = 1;
      #2 rst = 0;
      step();
      load_use(5);
      step();
      idle();
      check("rd_pre_stall", stall_cnt, 1);
      id_valid = 1; id_is_halt = 1;
      step();
      idle();
      step();
      #1 bit1("rd_draining", halt_signal, 1);
      rst = 1;
      #1;
      bit1("rd_rst_halt", halt_signal, 0);
      bit1("rd_rst_done", pipe_done, 0);
      check("rd_rst_stall", stall_cnt, 0);
      check("rd_rst_flush", flush_cnt, 0);
      rst = 0;
      #1 bit1("rd_run_halt", halt_signal, 0);
      load_use(9);
      #1 bit1("rd_run_haz", hazard_detected, 1);
      idle();
      for (int c = 0; c < DC + 2; c++) step();
      bit1("rd_no_done", pipe_done, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
